// File: rtl/fine_freq_track_ctrl_pkg.sv
// Shared types, default widths and helpers for the fine-frequency tracking controller.
//   dir_t        : loop decision (hold / up / down)
//   *_DEF        : default parameter values
//   sat_add_sub  : step a code up or down, clamped to [0, 2^width-1]
package fine_freq_track_pkg;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DN   = 2'b10
  } dir_t;

  localparam int unsigned CON_W_DEF        = 8;
  localparam int unsigned CON_INIT_DEF     = 128;
  localparam int unsigned DIV_W_DEF        = 6;
  localparam int unsigned ACC_W_DEF        = 24;
  localparam int unsigned STEP_W_DEF       = 4;
  localparam int unsigned LOCK_WINDOWS_DEF = 4;

  function automatic logic [31:0] sat_add_sub(input logic [31:0] code, input logic [31:0] step,
                                              input logic up, input int unsigned width);
    logic [32:0] max_v;
    logic [32:0] sum;
    max_v = (33'd1 << width) - 33'd1;
    sum   = {1'b0, code} + {1'b0, step};
    if (up) begin
      sat_add_sub = (sum > max_v) ? max_v[31:0] : sum[31:0];
    end else begin
      sat_add_sub = (step > code) ? 32'd0 : (code - step);
    end
  endfunction

endpackage

// File: rtl/fine_freq_track_ctrl_if.sv
// Control/status bundle of the fine-frequency tracking controller.
//   master : drives loop controls and the asynchronous ref_clk / aux_in inputs
//   slave  : the controller; returns out_star, fine_con, update, dir, locked
interface fine_freq_track_ctrl_if
  import fine_freq_track_pkg::*;
#(
  parameter int unsigned CON_W  = CON_W_DEF,
  parameter int unsigned DIV_W  = DIV_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned STEP_W = STEP_W_DEF
);
  logic              en;
  logic              ref_clk;
  logic              aux_in;
  logic [DIV_W-1:0]  div_ratio_half;
  logic [4:0]        avg_sel;
  logic [STEP_W-1:0] step_size;
  logic [ACC_W-1:0]  deadband;
  logic              freeze;
  logic              out_star;
  logic [CON_W-1:0]  fine_con;
  logic              update;
  dir_t              dir;
  logic              locked;

  modport master (
    output en, ref_clk, aux_in, div_ratio_half, avg_sel, step_size, deadband, freeze,
    input  out_star, fine_con, update, dir, locked
  );

  modport slave (
    input  en, ref_clk, aux_in, div_ratio_half, avg_sel, step_size, deadband, freeze,
    output out_star, fine_con, update, dir, locked
  );
endinterface

// File: rtl/fine_freq_track_ctrl_sync2.sv
// Two-flop synchroniser for a single asynchronous bit.
//   clk_i : destination clock   rst_i : async reset, active-high
//   d_i   : asynchronous input  q_o   : synchronised output (2 cycles latency)
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

// File: rtl/fine_freq_track_ctrl.sv
// Fine-frequency tracking controller, single clk_out domain.
//   clk_out : oscillator clock      rst : async reset, active-high
//   bus     : slave side of fine_freq_track_ctrl_if (controls in, out_star/fine_con/
//             update/dir/locked out)
// aux_in hits (on out_star) are binned by ref_clk phase into error/clean accumulators over
// 2^avg_sel ref_clk edges; each window end steps fine_con with deadband and saturation.
module fine_freq_track_ctrl
  import fine_freq_track_pkg::*;
#(
  parameter int unsigned CON_W        = CON_W_DEF,
  parameter int unsigned CON_INIT     = CON_INIT_DEF,
  parameter int unsigned DIV_W        = DIV_W_DEF,
  parameter int unsigned ACC_W        = ACC_W_DEF,
  parameter int unsigned STEP_W       = STEP_W_DEF,
  parameter int unsigned LOCK_WINDOWS = LOCK_WINDOWS_DEF
) (
  input logic                   clk_out,
  input logic                   rst,
  fine_freq_track_ctrl_if.slave bus
);
  localparam int unsigned HoldW = $clog2(LOCK_WINDOWS + 1);
  localparam logic [ACC_W-1:0] AccMax = '1;

  logic ref_s2, ref_s3_q, aux_s2, ref_rise;

  sync2 u_sync_ref (.clk_i(clk_out), .rst_i(rst), .d_i(bus.ref_clk), .q_o(ref_s2));
  sync2 u_sync_aux (.clk_i(clk_out), .rst_i(rst), .d_i(bus.aux_in),  .q_o(aux_s2));

  assign ref_rise = ref_s2 & ~ref_s3_q;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d, div_n;
  logic             out_star_q, out_star_d;
  logic [ACC_W-1:0] err_q, err_d, cln_q, cln_d, win_cnt_q, win_cnt_d, win_term;
  logic [4:0]       avg_c;
  logic             hit, err_hit, cln_hit, win_end, go_up, go_dn;
  dir_t             dec, dir_q, dir_d;
  logic [CON_W-1:0] fine_q, fine_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             update_q, update_d;

  // Divider: the >= compare makes a shrinking ratio wrap immediately.
  always_comb begin
    div_n      = (bus.div_ratio_half == '0) ? DIV_W'(1) : bus.div_ratio_half;
    div_cnt_d  = '0;
    out_star_d = 1'b0;
    if (bus.en) begin
      if (div_cnt_q >= div_n - DIV_W'(1)) begin
        out_star_d = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  // Hit binning and window accumulation.
  always_comb begin
    avg_c    = (bus.avg_sel > 5'(ACC_W - 1)) ? 5'(ACC_W - 1) : bus.avg_sel;
    win_term = (ACC_W'(1) << avg_c) - ACC_W'(1);
    hit      = out_star_q & aux_s2;
    err_hit  = hit & ref_s2;
    cln_hit  = hit & ~ref_s2;
    win_end  = bus.en & ref_rise & (win_cnt_q == win_term);
    err_d    = '0;
    cln_d    = '0;
    win_cnt_d = '0;
    if (bus.en) begin
      if (win_end) begin
        // The window-end cycle's hit opens the next window.
        err_d = ACC_W'(err_hit);
        cln_d = ACC_W'(cln_hit);
      end else begin
        err_d     = (err_hit && err_q != AccMax) ? err_q + ACC_W'(1) : err_q;
        cln_d     = (cln_hit && cln_q != AccMax) ? cln_q + ACC_W'(1) : cln_q;
        win_cnt_d = ref_rise ? win_cnt_q + ACC_W'(1) : win_cnt_q;
      end
    end
  end

  // Decision on the just-closed window; one extra bit keeps the sums from overflowing.
  always_comb begin
    go_dn = {1'b0, cln_q} > ({1'b0, err_q} + {1'b0, bus.deadband});
    go_up = {1'b0, err_q} > ({1'b0, cln_q} + {1'b0, bus.deadband});
    dec   = go_dn ? DIR_DN : (go_up ? DIR_UP : DIR_HOLD);
    update_d = win_end;
    dir_d    = dir_q;
    fine_d   = fine_q;
    hold_d   = bus.en ? hold_q : '0;
    if (win_end) begin
      dir_d = dec;
      if (dec == DIR_HOLD) begin
        hold_d = (hold_q == HoldW'(LOCK_WINDOWS)) ? hold_q : hold_q + HoldW'(1);
      end else begin
        hold_d = '0;
        if (!bus.freeze) begin
          fine_d = CON_W'(sat_add_sub(32'(fine_q), 32'(bus.step_size), dec == DIR_UP, CON_W));
        end
      end
    end
  end

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      ref_s3_q   <= 1'b0;
      div_cnt_q  <= '0;
      out_star_q <= 1'b0;
      err_q      <= '0;
      cln_q      <= '0;
      win_cnt_q  <= '0;
      dir_q      <= DIR_HOLD;
      fine_q     <= CON_W'(CON_INIT);
      hold_q     <= '0;
      update_q   <= 1'b0;
    end else begin
      ref_s3_q   <= ref_s2;
      div_cnt_q  <= div_cnt_d;
      out_star_q <= out_star_d;
      err_q      <= err_d;
      cln_q      <= cln_d;
      win_cnt_q  <= win_cnt_d;
      dir_q      <= dir_d;
      fine_q     <= fine_d;
      hold_q     <= hold_d;
      update_q   <= update_d;
    end
  end

  assign bus.out_star = out_star_q;
  assign bus.fine_con = fine_q;
  assign bus.update   = update_q;
  assign bus.dir      = dir_q;
  assign bus.locked   = bus.en & (hold_q == HoldW'(LOCK_WINDOWS));
endmodule

// File: tb/tb_fine_freq_track_ctrl.sv
// Directed bench for fine_freq_track_ctrl: reset values, divider cadence, window decisions
// (table of consecutive windows), freeze, lock, floor saturation, mid-window reset,
// div_ratio_half=0 and loop disable.
module tb_fine_freq_track_ctrl;
  import fine_freq_track_pkg::*;

  localparam int unsigned CON_W  = 8;
  localparam int unsigned DIV_W  = 6;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned STEP_W = 4;

  logic clk_out = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_out = ~clk_out;

  fine_freq_track_ctrl_if #(.CON_W(CON_W), .DIV_W(DIV_W), .ACC_W(ACC_W), .STEP_W(STEP_W)) bus ();

  fine_freq_track_ctrl #(
    .CON_W(CON_W), .CON_INIT(128), .DIV_W(DIV_W), .ACC_W(ACC_W), .STEP_W(STEP_W),
    .LOCK_WINDOWS(4)
  ) dut (
    .clk_out(clk_out),
    .rst    (rst),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  int ref_edges = 0;
  int edges0;
  logic ref_run = 1'b0;
  int aux_mode = 0;  // 0: aux low, 1: aux = ref_clk, 2: aux = ~ref_clk

  // ref_clk = clk_out/40, offset so its edges never land on clk_out edges.
  initial begin
    bus.ref_clk = 1'b0;
    #3;
    forever begin
      #200;
      if (ref_run) begin
        bus.ref_clk = ~bus.ref_clk;
        if (bus.ref_clk) ref_edges++;
      end else begin
        bus.ref_clk = 1'b0;
      end
    end
  end

  assign bus.aux_in = (aux_mode == 1) ? bus.ref_clk : ((aux_mode == 2) ? ~bus.ref_clk : 1'b0);

  typedef struct {
    int mode;
    int step;
    bit frz;
    int exp_dir;
    int exp_con;
    bit exp_lock;
  } vec_t;
  vec_t tbl [23];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_update(input string name);
    int n;
    n = 0;
    while (bus.update !== 1'b1 && n < 600) begin
      @(negedge clk_out);
      n++;
    end
    if (bus.update !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s: got no update expected one within 600 cycles", name);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.en             = 1'b0;
    bus.div_ratio_half = 6'd5;
    bus.avg_sel        = 5'd2;
    bus.step_size      = 4'd3;
    bus.deadband       = '0;
    bus.freeze         = 1'b0;

    // mode, step, freeze, dir, fine_con, locked (deadband 2, avg_sel 2)
    tbl[0]  = '{0, 3,  1'b0, 0, 131, 1'b0};
    tbl[1]  = '{0, 3,  1'b0, 0, 131, 1'b0};
    tbl[2]  = '{0, 3,  1'b0, 0, 131, 1'b0};
    tbl[3]  = '{0, 3,  1'b0, 0, 131, 1'b1};
    tbl[4]  = '{0, 3,  1'b0, 0, 131, 1'b1};
    tbl[5]  = '{1, 3,  1'b0, 1, 134, 1'b0};
    tbl[6]  = '{1, 3,  1'b1, 1, 134, 1'b0};
    tbl[7]  = '{1, 3,  1'b1, 1, 134, 1'b0};
    tbl[8]  = '{1, 3,  1'b0, 1, 137, 1'b0};
    tbl[9]  = '{2, 15, 1'b0, 2, 122, 1'b0};
    tbl[10] = '{2, 15, 1'b0, 2, 107, 1'b0};
    tbl[11] = '{2, 15, 1'b0, 2, 92,  1'b0};
    tbl[12] = '{2, 15, 1'b0, 2, 77,  1'b0};
    tbl[13] = '{2, 15, 1'b0, 2, 62,  1'b0};
    tbl[14] = '{2, 15, 1'b0, 2, 47,  1'b0};
    tbl[15] = '{2, 15, 1'b0, 2, 32,  1'b0};
    tbl[16] = '{2, 15, 1'b0, 2, 17,  1'b0};
    tbl[17] = '{2, 15, 1'b0, 2, 2,   1'b0};
    tbl[18] = '{2, 15, 1'b0, 2, 0,   1'b0};
    tbl[19] = '{2, 15, 1'b0, 2, 0,   1'b0};
    tbl[20] = '{2, 15, 1'b1, 2, 0,   1'b0};
    tbl[21] = '{0, 15, 1'b0, 0, 0,   1'b0};
    tbl[22] = '{1, 15, 1'b0, 1, 15,  1'b0};

    // Reset values
    #12;
    chk("rst_fine_con", int'(bus.fine_con), 128);
    chk("rst_out_star", int'(bus.out_star), 0);
    chk("rst_dir",      int'(bus.dir), 0);
    chk("rst_locked",   int'(bus.locked), 0);
    chk("rst_update",   int'(bus.update), 0);

    // Divider cadence, ratio 5
    @(negedge clk_out);
    rst    = 1'b0;
    bus.en = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk_out);
      chk("div5_out_star", int'(bus.out_star), (i % 5 == 0) ? 1 : 0);
    end

    // First window: error-dominant, deadband 0, step 3
    bus.en = 1'b0;
    repeat (2) @(negedge clk_out);
    bus.en   = 1'b1;
    aux_mode = 1;
    ref_run  = 1'b1;
    edges0   = ref_edges;
    wait_update("t2_update");
    chk("t2_ref_edges", ref_edges - edges0, 4);
    chk("t2_dir",       int'(bus.dir), 1);
    chk("t2_fine_con",  int'(bus.fine_con), 131);
    chk("t2_locked",    int'(bus.locked), 0);

    // Consecutive windows, inputs switched right at each update
    bus.deadband = 24'd2;
    for (int i = 0; i < 23; i++) begin
      aux_mode      = tbl[i].mode;
      bus.step_size = STEP_W'(tbl[i].step);
      bus.freeze    = tbl[i].frz;
      @(negedge clk_out);
      chk("tbl_update_width", int'(bus.update), 0);
      wait_update("tbl_update");
      chk($sformatf("tbl%0d_dir", i),      int'(bus.dir), tbl[i].exp_dir);
      chk($sformatf("tbl%0d_fine_con", i), int'(bus.fine_con), tbl[i].exp_con);
      chk($sformatf("tbl%0d_locked", i),   int'(bus.locked), int'(tbl[i].exp_lock));
    end

    // Mid-window reset with a large error count pending
    bus.avg_sel   = 5'd3;
    bus.deadband  = '0;
    bus.step_size = 4'd3;
    bus.freeze    = 1'b0;
    aux_mode      = 1;
    repeat (250) @(negedge clk_out);
    rst = 1'b1;
    #1;
    chk("mid_rst_fine_con", int'(bus.fine_con), 128);
    chk("mid_rst_dir",      int'(bus.dir), 0);
    chk("mid_rst_locked",   int'(bus.locked), 0);
    chk("mid_rst_out_star", int'(bus.out_star), 0);
    chk("mid_rst_update",   int'(bus.update), 0);
    bus.avg_sel = 5'd2;
    aux_mode    = 2;
    repeat (3) @(negedge clk_out);
    rst = 1'b0;
    wait_update("post_rst_update");
    chk("post_rst_dir",      int'(bus.dir), 2);
    chk("post_rst_fine_con", int'(bus.fine_con), 125);

    // div_ratio_half = 0 behaves as 1
    bus.div_ratio_half = '0;
    repeat (2) @(negedge clk_out);
    for (int i = 0; i < 4; i++) begin
      chk("div0_out_star", int'(bus.out_star), 1);
      @(negedge clk_out);
    end

    // Loop disable keeps fine_con/dir, silences the rest
    bus.en = 1'b0;
    @(negedge clk_out);
    chk("dis_out_star", int'(bus.out_star), 0);
    chk("dis_update",   int'(bus.update), 0);
    chk("dis_locked",   int'(bus.locked), 0);
    chk("dis_fine_con", int'(bus.fine_con), 125);
    chk("dis_dir",      int'(bus.dir), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
